// File: rtl/ca_gen_controller.sv
// Sequencer for the 8x8 cellular-automaton datapath: owns the live grid,
// loads seeds, requests generations over req/ack and commits results.
module ca_gen_controller #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       load,
  input  logic [ROWS-1:0][COLS-1:0]  seed_in,
  input  logic                       run,
  input  logic                       step,
  output logic                       calc_req,
  output logic [ROWS-1:0][COLS-1:0]  calc_grid,
  input  logic                       calc_ack,
  input  logic [ROWS-1:0][COLS-1:0]  calc_next,
  output logic [ROWS-1:0][COLS-1:0]  grid_out,
  output logic [GEN_W-1:0]           gen_count,
  output logic                       busy,
  output logic                       stable
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t                    state;
  logic [ROWS-1:0][COLS-1:0] grid;
  logic [TW-1:0]             tick_cnt;
  logic                      tick_en;
  logic                      tick_hit;
  logic                      trigger;

  // A stable grid only stops the free-running rate divider, never step.
  assign tick_en  = run && !stable;
  assign tick_hit = (tick_cnt == TW'(TICK_DIV - 1));
  assign trigger  = step || (tick_en && tick_hit);

  assign calc_req  = (state == REQ);
  assign busy      = (state == REQ);
  assign calc_grid = grid;
  assign grid_out  = grid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grid      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      tick_cnt  <= '0;
    end else if (clear) begin
      state     <= IDLE;
      grid      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      tick_cnt  <= '0;
    end else if (load) begin
      state     <= IDLE;
      grid      <= seed_in;
      gen_count <= '0;
      stable    <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state    <= REQ;
            tick_cnt <= '0;
          end else if (tick_en) begin
            tick_cnt <= tick_cnt + 1'b1;
          end else begin
            tick_cnt <= '0;
          end
        end
        REQ: begin
          if (calc_ack) begin
            state     <= IDLE;
            grid      <= calc_next;
            gen_count <= gen_count + 1'b1;
            stable    <= (calc_next == grid);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_gen_controller.sv
// Randomised scoreboard bench for ca_gen_controller against a
// cycle-level behavioural model of the generation sequencer.
module tb_ca_gen_controller;

  localparam int R  = 8;
  localparam int C  = 8;
  localparam int TD = 4;
  localparam int GW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 load = 1'b0;
  logic                 run = 1'b0;
  logic                 step = 1'b0;
  logic                 calc_ack = 1'b0;
  logic [R-1:0][C-1:0]  seed_in = '0;
  logic [R-1:0][C-1:0]  calc_next = '0;
  logic                 calc_req;
  logic                 busy;
  logic                 stable;
  logic [R-1:0][C-1:0]  calc_grid;
  logic [R-1:0][C-1:0]  grid_out;
  logic [GW-1:0]        gen_count;

  ca_gen_controller #(
    .ROWS(R), .COLS(C), .TICK_DIV(TD), .GEN_W(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
    .seed_in(seed_in), .run(run), .step(step),
    .calc_req(calc_req), .calc_grid(calc_grid),
    .calc_ack(calc_ack), .calc_next(calc_next),
    .grid_out(grid_out), .gen_count(gen_count),
    .busy(busy), .stable(stable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   grid;
    logic [GW-1:0] gen;
    logic          st;
    logic          req;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total = 0;
  int req_hi = 0;

  logic [63:0] m_grid = '0;
  int m_gen = 0;
  bit m_st = 0;
  bit m_req = 0;
  int m_tick = 0;
  int m_age = 0;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1c00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Generation rules expressed as events: clear/load win, a pending
  // request commits on ack, otherwise step or the run-rate divider fires.
  task automatic model(bit c, bit l, logic [63:0] sd, bit r, bit s,
                       bit a, logic [63:0] nx);
    if (c) begin
      m_grid = '0; m_gen = 0; m_st = 0; m_tick = 0; m_req = 0;
    end else if (l) begin
      m_grid = sd; m_gen = 0; m_st = 0; m_tick = 0; m_req = 0;
    end else if (m_req) begin
      if (a) begin
        m_st = (nx == m_grid);
        m_grid = nx;
        m_gen = (m_gen + 1) % (1 << GW);
        m_req = 0;
      end else begin
        m_age++;
      end
    end else if (s || (r && !m_st && m_tick == TD - 1)) begin
      m_req = 1; m_tick = 0; m_age = 0;
    end else begin
      m_tick = (r && !m_st) ? m_tick + 1 : 0;
    end
  endtask

  task automatic cyc(bit c, bit l, logic [63:0] sd, bit r, bit s,
                     bit a, logic [63:0] nx);
    exp_t e;
    clear = c; load = l; seed_in = sd; run = r; step = s;
    calc_ack = a; calc_next = nx;
    model(c, l, sd, r, s, a, nx);
    e.grid = m_grid; e.gen = GW'(m_gen); e.st = m_st; e.req = m_req;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] nxt(int mode);
    case (mode)
      0: return ~m_grid;
      1: return m_grid;
      3: return BLINK_V;
      default: return rnd64();
    endcase
  endfunction

  task automatic run_cycles(int n, bit r, int dly, int mode);
    for (int i = 0; i < n; i++)
      cyc(0, 0, '0, r, 0, m_req && m_age >= dly, nxt(mode));
  endtask

  task automatic do_step(bit r, int dly, int mode);
    int k;
    cyc(0, 0, '0, r, 1, 0, '0);
    k = 0;
    while (m_req && k < 20) begin
      run_cycles(1, r, dly, mode);
      k++;
    end
    if (m_req) chk("step_timeout", 64'(k), 64'(0));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        chk("grid_out", grid_out, e.grid);
        chk("calc_grid", calc_grid, e.grid);
        chk("gen_count", 64'(gen_count), 64'(e.gen));
        chk("flags", 64'({stable, busy, calc_req}), 64'({e.st, e.req, e.req}));
      end
    end
  end

  always @(negedge clk) if (calc_req) req_hi++;

  initial begin : stim
    int k;
    #3;
    chk("rst_grid", grid_out, '0);
    chk("rst_gen", 64'(gen_count), 64'(0));
    chk("rst_flags", 64'({stable, busy, calc_req}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Blinker: ack on third REQ cycle
    cyc(0, 1, BLINK_H, 0, 0, 0, '0);
    req_hi = 0;
    do_step(0, 2, 3);
    run_cycles(2, 0, 0, 2);
    chk("blink_req_cycles", 64'(req_hi), 64'(3));
    chk("blink_grid", grid_out, BLINK_V);
    chk("blink_gen", 64'(gen_count), 64'(1));
    chk("blink_stable", 64'(stable), 64'(0));

    // Free-run: ten generations, one every TD+1 cycles
    cyc(0, 1, rnd64() | 64'h1, 0, 0, 0, '0);
    k = 0;
    while (gen_count != GW'(10) && k < 200) begin
      run_cycles(1, 1, 0, 0);
      k++;
    end
    chk("run_cycles_to_10", 64'(k), 64'(10 * (TD + 1)));
    run_cycles(3, 0, 0, 0);
    chk("run_gen", 64'(gen_count), 64'(10));

    // Still-life block goes stable and stops auto triggers
    cyc(0, 1, BLOCK, 0, 0, 0, '0);
    run_cycles(30, 1, 0, 1);
    chk("block_gen", 64'(gen_count), 64'(1));
    chk("block_stable", 64'(stable), 64'(1));
    chk("block_idle", 64'(calc_req), 64'(0));
    do_step(1, 0, 1);
    run_cycles(5, 1, 0, 1);
    chk("block_step_gen", 64'(gen_count), 64'(2));
    chk("block_step_stable", 64'(stable), 64'(1));

    // load collides with ack
    cyc(0, 0, '0, 0, 1, 0, '0);
    cyc(0, 1, BLINK_H, 0, 0, 1, rnd64());
    run_cycles(3, 0, 0, 2);
    chk("load_ack_grid", grid_out, BLINK_H);
    chk("load_ack_gen", 64'(gen_count), 64'(0));

    // Counter wrap
    for (int i = 0; i < 17; i++) do_step(0, int'($urandom_range(0, 2)), 2);
    chk("wrap_gen", 64'(gen_count), 64'(17 % (1 << GW)));

    // clear during REQ, then stray ack while idle
    cyc(0, 0, '0, 0, 1, 0, '0);
    cyc(1, 0, '0, 0, 0, 1, rnd64());
    chk("clear_grid", grid_out, '0);
    cyc(0, 0, '0, 0, 0, 1, rnd64());
    run_cycles(2, 0, 0, 2);
    chk("idle_ack_gen", 64'(gen_count), 64'(0));

    // Random mix
    for (int i = 0; i < 600; i++) begin
      bit c, l, s, a, r;
      logic [63:0] nx;
      c = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 19) == 0) ? !run : run;
      nx = ($urandom_range(0, 4) == 0) ? m_grid : rnd64();
      cyc(c, l, rnd64(), r, s, a, nx);
    end

    // Asynchronous reset mid-request
    cyc(0, 1, rnd64() | 64'h80, 0, 0, 0, '0);
    do_step(0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0, '0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(calc_req), 64'(0));
    chk("arst_grid", grid_out, '0);
    chk("arst_gen", 64'(gen_count), 64'(0));
    chk("arst_flags", 64'({stable, busy}), 64'(0));
    m_grid = '0; m_gen = 0; m_st = 0; m_req = 0; m_tick = 0;
    clear = 0; load = 0; step = 0; run = 0; calc_ack = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycles(3, 0, 0, 2);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
